// File: rtl/spi_dac_frame_ctrl.sv
// Frame sequencer for an MCP4921-style DAC: wraps 12-bit samples into {CFG, sample}
// command frames and drives chip-select, LDAC and two byte transfers on the SPI byte engine.
module spi_dac_frame_ctrl #(
    parameter logic [3:0] CFG      = 4'b0011,
    parameter int         CS_SETUP = 2,
    parameter int         CS_HOLD  = 2,
    parameter int         CS_GAP   = 4,
    parameter bit         LDAC_EN  = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] sample_in,
    input  logic        sample_valid,
    output logic        sample_ready,
    output logic        cs_n,
    output logic        ldac_n,
    output logic        spi_start,
    output logic [7:0]  spi_data,
    input  logic        spi_busy,
    input  logic        spi_new_data,
    input  logic [7:0]  spi_rx,
    output logic [15:0] rx_word,
    output logic        frame_done,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        START_HI,
        WAIT_HI,
        START_LO,
        WAIT_LO,
        HOLD,
        GAP
    } state_t;

    localparam logic [7:0] SETUP_INIT = 8'(CS_SETUP - 1);
    localparam logic [7:0] HOLD_INIT  = 8'(CS_HOLD - 1);
    localparam logic [7:0] GAP_INIT   = 8'(CS_GAP - 1);

    state_t      state;
    state_t      state_next;
    logic [7:0]  cnt;
    logic [15:0] frame;
    logic [11:0] pend;
    logic        pend_full;
    logic [7:0]  rx_hi;
    logic        accept;
    logic        launch;

    assign sample_ready = !pend_full && !rst;
    assign accept       = sample_valid && sample_ready;
    assign busy         = (state != IDLE) || pend_full;

    // The last GAP cycle doubles as IDLE so a queued sample sees exactly CS_GAP high cycles.
    assign launch = pend_full && ((state == IDLE) || ((state == GAP) && (cnt == 8'd0)));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (pend_full)      state_next = SETUP;
            SETUP:    if (cnt == 8'd0)    state_next = START_HI;
            START_HI: if (!spi_busy)      state_next = WAIT_HI;
            WAIT_HI:  if (spi_new_data)   state_next = START_LO;
            START_LO: if (!spi_busy)      state_next = WAIT_LO;
            WAIT_LO:  if (spi_new_data)   state_next = HOLD;
            HOLD:     if (cnt == 8'd0)    state_next = GAP;
            GAP:      if (cnt == 8'd0)    state_next = pend_full ? SETUP : IDLE;
            default:                      state_next = IDLE;
        endcase
    end

    always_comb begin
        spi_start = 1'b0;
        spi_data  = 8'h00;
        case (state)
            START_HI: begin
                spi_start = !spi_busy;
                spi_data  = frame[15:8];
            end
            START_LO: begin
                spi_start = !spi_busy;
                spi_data  = frame[7:0];
            end
            default: begin
            end
        endcase
    end

    // Frame datapath; the sample load is last so a same-cycle handshake wins over the clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            cs_n       <= 1'b1;
            ldac_n     <= 1'b1;
            frame_done <= 1'b0;
            rx_word    <= 16'h0000;
            rx_hi      <= 8'h00;
            frame      <= 16'h0000;
            pend       <= 12'h000;
            pend_full  <= 1'b0;
            cnt        <= 8'd0;
        end else begin
            frame_done <= 1'b0;
            ldac_n     <= 1'b1;
            if (launch) begin
                frame     <= {CFG, pend};
                pend_full <= 1'b0;
                cs_n      <= 1'b0;
                cnt       <= SETUP_INIT;
            end
            case (state)
                SETUP: begin
                    if (cnt != 8'd0) cnt <= cnt - 8'd1;
                end
                WAIT_HI: begin
                    if (spi_new_data) rx_hi <= spi_rx;
                end
                WAIT_LO: begin
                    if (spi_new_data) begin
                        rx_word <= {rx_hi, spi_rx};
                        cnt     <= HOLD_INIT;
                    end
                end
                HOLD: begin
                    if (cnt == 8'd0) begin
                        cs_n       <= 1'b1;
                        frame_done <= 1'b1;
                        ldac_n     <= ~LDAC_EN;
                        cnt        <= GAP_INIT;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                GAP: begin
                    if (cnt != 8'd0) cnt <= cnt - 8'd1;
                end
                default: begin
                end
            endcase
            if (accept) begin
                pend      <= sample_in;
                pend_full <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_spi_dac_frame_ctrl.sv
// Scoreboard bench for spi_dac_frame_ctrl: two instances (default timing, and minimal
// timing with LDAC disabled), each paired with a small byte-engine model.
module tb_spi_dac_frame_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [11:0] sample_in    [2] = '{12'h000, 12'h000};
    logic        sample_valid [2] = '{1'b0, 1'b0};
    logic        sample_ready [2];
    logic        cs_n         [2];
    logic        ldac_n       [2];
    logic        spi_start    [2];
    logic [7:0]  spi_data     [2];
    logic        spi_busy     [2];
    logic        spi_new_data [2] = '{1'b0, 1'b0};
    logic [7:0]  spi_rx       [2] = '{8'h00, 8'h00};
    logic [15:0] rx_word      [2];
    logic        frame_done   [2];
    logic        busy         [2];

    logic eng_busy   [2] = '{1'b0, 1'b0};
    logic eng_active [2] = '{1'b0, 1'b0};
    logic force_busy [2] = '{1'b0, 1'b0};
    int   eng_cnt    [2];

    assign spi_busy[0] = eng_busy[0] | force_busy[0];
    assign spi_busy[1] = eng_busy[1] | force_busy[1];

    spi_dac_frame_ctrl #(
        .CFG(4'b0011), .CS_SETUP(2), .CS_HOLD(2), .CS_GAP(4), .LDAC_EN(1'b1)
    ) dut0 (
        .clk(clk), .rst(rst),
        .sample_in(sample_in[0]), .sample_valid(sample_valid[0]), .sample_ready(sample_ready[0]),
        .cs_n(cs_n[0]), .ldac_n(ldac_n[0]), .spi_start(spi_start[0]), .spi_data(spi_data[0]),
        .spi_busy(spi_busy[0]), .spi_new_data(spi_new_data[0]), .spi_rx(spi_rx[0]),
        .rx_word(rx_word[0]), .frame_done(frame_done[0]), .busy(busy[0])
    );

    spi_dac_frame_ctrl #(
        .CFG(4'b0011), .CS_SETUP(1), .CS_HOLD(1), .CS_GAP(1), .LDAC_EN(1'b0)
    ) dut1 (
        .clk(clk), .rst(rst),
        .sample_in(sample_in[1]), .sample_valid(sample_valid[1]), .sample_ready(sample_ready[1]),
        .cs_n(cs_n[1]), .ldac_n(ldac_n[1]), .spi_start(spi_start[1]), .spi_data(spi_data[1]),
        .spi_busy(spi_busy[1]), .spi_new_data(spi_new_data[1]), .spi_rx(spi_rx[1]),
        .rx_word(rx_word[1]), .frame_done(frame_done[1]), .busy(busy[1])
    );

    int checks = 0;
    int fails  = 0;

    logic [7:0]  exp_byte_q0 [$];
    logic [7:0]  exp_byte_q1 [$];
    logic [15:0] exp_word_q0 [$];
    logic [15:0] exp_word_q1 [$];
    logic [7:0]  rx_q0 [$];
    logic [7:0]  rx_q1 [$];

    int   cyc         [2];
    int   cs_fall_cyc [2];
    int   cs_rise_cyc [2];
    int   nd_cyc      [2];
    int   last_gap    [2];
    int   byte_idx    [2];
    int   frames      [2];
    int   starts      [2];
    int   ldac_lows   [2];
    int   exp_extra   [2];
    int   spur_req    [2];
    int   spur_ack    [2];
    int   abort_req   [2];
    int   abort_ack   [2];
    logic prev_cs     [2] = '{1'b1, 1'b1};
    logic prev_start  [2] = '{1'b0, 1'b0};

    function automatic int pSetup(input int i);
        return (i == 0) ? 2 : 1;
    endfunction

    function automatic int pHold(input int i);
        return (i == 0) ? 2 : 1;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    function automatic logic popByte(input int i, output logic [7:0] b);
        b = 8'h00;
        if (i == 0 && exp_byte_q0.size() > 0) begin b = exp_byte_q0.pop_front(); return 1'b1; end
        if (i == 1 && exp_byte_q1.size() > 0) begin b = exp_byte_q1.pop_front(); return 1'b1; end
        return 1'b0;
    endfunction

    function automatic logic popWord(input int i, output logic [15:0] w);
        w = 16'h0000;
        if (i == 0 && exp_word_q0.size() > 0) begin w = exp_word_q0.pop_front(); return 1'b1; end
        if (i == 1 && exp_word_q1.size() > 0) begin w = exp_word_q1.pop_front(); return 1'b1; end
        return 1'b0;
    endfunction

    function automatic logic [7:0] popRx(input int i);
        if (i == 0 && rx_q0.size() > 0) return rx_q0.pop_front();
        if (i == 1 && rx_q1.size() > 0) return rx_q1.pop_front();
        return 8'hEE;
    endfunction

    // Observe DUT outputs mid-cycle, then advance the byte-engine model for the next edge.
    task automatic monitorDut(input int i);
        logic [7:0]  eb;
        logic [15:0] ew;
        cyc[i]++;
        if (prev_cs[i] && !cs_n[i]) begin
            last_gap[i]    = cyc[i] - cs_rise_cyc[i];
            cs_fall_cyc[i] = cyc[i];
            byte_idx[i]    = 0;
        end
        if (!prev_cs[i] && cs_n[i]) begin
            cs_rise_cyc[i] = cyc[i];
            if (abort_req[i] != abort_ack[i]) begin
                abort_ack[i] = abort_req[i];
                checkOutput("abort_no_frame_done", frame_done[i], 1'b0);
            end else begin
                checkOutput("cs_hold_cycles", cyc[i] - nd_cyc[i], pHold(i) + 1);
                checkOutput("frame_done_on_cs_rise", frame_done[i], 1'b1);
            end
        end
        if (frame_done[i]) begin
            frames[i]++;
            if (popWord(i, ew)) checkOutput("rx_word", rx_word[i], ew);
            else checkOutput("unexpected_frame_done", 1, 0);
        end
        if (!ldac_n[i]) begin
            ldac_lows[i]++;
            checkOutput("ldac_with_frame_done", frame_done[i], 1'b1);
        end
        if (spi_start[i]) begin
            checkOutput("start_not_back_to_back", prev_start[i], 1'b0);
            checkOutput("start_with_cs_low", cs_n[i], 1'b0);
            checkOutput("one_byte_outstanding", eng_active[i], 1'b0);
            if (byte_idx[i] == 0)
                checkOutput("setup_latency", cyc[i] - cs_fall_cyc[i], pSetup(i) + exp_extra[i]);
            if (popByte(i, eb)) checkOutput("spi_data", spi_data[i], eb);
            else checkOutput("unexpected_spi_start", 1, 0);
            byte_idx[i]++;
            starts[i]++;
        end
        prev_cs[i]    = cs_n[i];
        prev_start[i] = spi_start[i];

        spi_new_data[i] = 1'b0;
        if (spur_req[i] != spur_ack[i]) begin
            spur_ack[i]     = spur_req[i];
            spi_new_data[i] = 1'b1;
            spi_rx[i]       = 8'h77;
        end
        if (rst) begin
            eng_active[i] = 1'b0;
            eng_busy[i]   = 1'b0;
        end else if (eng_active[i]) begin
            eng_busy[i] = 1'b1;
            if (eng_cnt[i] == 0) begin
                eng_busy[i]     = 1'b0;
                eng_active[i]   = 1'b0;
                spi_new_data[i] = 1'b1;
                spi_rx[i]       = popRx(i);
                nd_cyc[i]       = cyc[i];
            end else begin
                eng_cnt[i]--;
            end
        end else if (spi_start[i]) begin
            eng_active[i] = 1'b1;
            eng_cnt[i]    = 2;
        end
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) monitorDut(i);
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Offer one sample, record the frame bytes and returned word it must produce.
    task automatic applyStimulus(input int i, input logic [11:0] s, input logic [7:0] hi, input logic [7:0] lo,
                                 input bit keep_valid);
        int guard = 0;
        while (!sample_ready[i] && guard < 200) begin
            tick();
            guard++;
        end
        if (guard >= 200) checkOutput("ready_timeout", 0, 1);
        sample_in[i]    = s;
        sample_valid[i] = 1'b1;
        if (i == 0) begin
            exp_byte_q0.push_back({4'h3, s[11:8]});
            exp_byte_q0.push_back(s[7:0]);
            exp_word_q0.push_back({hi, lo});
            rx_q0.push_back(hi);
            rx_q0.push_back(lo);
        end else begin
            exp_byte_q1.push_back({4'h3, s[11:8]});
            exp_byte_q1.push_back(s[7:0]);
            exp_word_q1.push_back({hi, lo});
            rx_q1.push_back(hi);
            rx_q1.push_back(lo);
        end
        tick();
        checkOutput("ready_low_when_full", sample_ready[i], 1'b0);
        checkOutput("busy_when_full", busy[i], 1'b1);
        if (!keep_valid) sample_valid[i] = 1'b0;
    endtask

    task automatic waitFrames(input int i, input int target);
        int guard = 0;
        while (frames[i] < target && guard < 400) begin
            tick();
            guard++;
        end
        if (frames[i] < target) checkOutput("frame_timeout", frames[i], target);
    endtask

    task automatic waitIdle(input int i);
        int guard = 0;
        while (busy[i] && guard < 200) begin
            tick();
            guard++;
        end
        if (busy[i]) checkOutput("idle_timeout", busy[i], 1'b0);
        tick();
        tick();
    endtask

    task automatic waitCsLow(input int i);
        int guard = 0;
        while (cs_n[i] && guard < 50) begin
            tick();
            guard++;
        end
        if (cs_n[i]) checkOutput("cs_low_timeout", cs_n[i], 1'b0);
    endtask

    initial begin
        int base_starts;
        int base_frames;
        repeat (3) tick();
        for (int i = 0; i < 2; i++) begin
            checkOutput("reset_cs_n", cs_n[i], 1'b1);
            checkOutput("reset_ldac_n", ldac_n[i], 1'b1);
            checkOutput("reset_spi_start", spi_start[i], 1'b0);
            checkOutput("reset_spi_data", spi_data[i], 8'h00);
            checkOutput("reset_rx_word", rx_word[i], 16'h0000);
            checkOutput("reset_frame_done", frame_done[i], 1'b0);
            checkOutput("reset_busy", busy[i], 1'b0);
            checkOutput("reset_ready_in_rst", sample_ready[i], 1'b0);
        end
        rst = 1'b0;
        #1;
        checkOutput("ready_after_rst", sample_ready[0], 1'b1);
        tick();

        $display("[TB] single frame 0xABC");
        applyStimulus(0, 12'hABC, 8'h5A, 8'hC3, 1'b0);
        waitFrames(0, 1);
        waitIdle(0);
        checkOutput("t1_rx_word", rx_word[0], 16'h5AC3);
        checkOutput("t1_frames", frames[0], 1);
        checkOutput("t1_ldac_pulses", ldac_lows[0], 1);
        checkOutput("t1_starts", starts[0], 2);

        $display("[TB] back-to-back 0x000, 0xFFF");
        applyStimulus(0, 12'h000, 8'h11, 8'h22, 1'b1);
        applyStimulus(0, 12'hFFF, 8'h33, 8'h44, 1'b0);
        checkOutput("t2_accept_mid_frame", cs_n[0], 1'b0);
        waitFrames(0, 3);
        checkOutput("t2_gap_cycles", last_gap[0], 4);
        waitIdle(0);
        checkOutput("t2_rx_word", rx_word[0], 16'h3344);
        checkOutput("t2_starts", starts[0], 6);
        checkOutput("t2_ldac_pulses", ldac_lows[0], 3);

        $display("[TB] engine busy stall");
        exp_extra[0] = 5;
        applyStimulus(0, 12'h5A5, 8'h01, 8'h02, 1'b0);
        force_busy[0] = 1'b1;
        waitCsLow(0);
        for (int k = 0; k < 7; k++) begin
            tick();
            checkOutput("t3_no_start_while_busy", spi_start[0], 1'b0);
            checkOutput("t3_cs_low_while_busy", cs_n[0], 1'b0);
        end
        force_busy[0] = 1'b0;
        waitFrames(0, 4);
        waitIdle(0);
        exp_extra[0] = 0;
        checkOutput("t3_starts", starts[0], 8);

        $display("[TB] reset in WAIT_LO");
        base_starts = starts[0];
        base_frames = frames[0];
        applyStimulus(0, 12'h321, 8'hAA, 8'hBB, 1'b1);
        applyStimulus(0, 12'h654, 8'hCC, 8'hDD, 1'b0);
        for (int g = 0; g < 50 && starts[0] < base_starts + 2; g++) tick();
        checkOutput("t4_reached_wait_lo", starts[0], base_starts + 2);
        checkOutput("t4_pend_full", sample_ready[0], 1'b0);
        rst = 1'b1;
        abort_req[0]++;
        exp_byte_q0.delete();
        exp_word_q0.delete();
        rx_q0.delete();
        tick();
        checkOutput("t4_cs_n", cs_n[0], 1'b1);
        checkOutput("t4_busy", busy[0], 1'b0);
        checkOutput("t4_frame_done", frame_done[0], 1'b0);
        checkOutput("t4_rx_word", rx_word[0], 16'h0000);
        checkOutput("t4_spi_start", spi_start[0], 1'b0);
        rst = 1'b0;
        #1;
        checkOutput("t4_ready", sample_ready[0], 1'b1);
        repeat (20) tick();
        checkOutput("t4_no_more_starts", starts[0], base_starts + 2);
        checkOutput("t4_no_frame_done", frames[0], base_frames);
        checkOutput("t4_cs_stays_high", cs_n[0], 1'b1);

        $display("[TB] minimal timing, LDAC off");
        applyStimulus(1, 12'h123, 8'h9C, 8'h6B, 1'b1);
        applyStimulus(1, 12'h456, 8'h12, 8'h34, 1'b0);
        waitFrames(1, 2);
        waitIdle(1);
        checkOutput("t5_gap_cycles", last_gap[1], 1);
        checkOutput("t5_ldac_never_low", ldac_lows[1], 0);
        checkOutput("t5_ldac_n", ldac_n[1], 1'b1);
        checkOutput("t5_rx_word", rx_word[1], 16'h1234);
        checkOutput("t5_starts", starts[1], 4);

        $display("[TB] spurious spi_new_data in SETUP and GAP");
        base_frames = frames[0];
        applyStimulus(0, 12'h777, 8'h55, 8'h66, 1'b0);
        waitCsLow(0);
        spur_req[0]++;
        applyStimulus(0, 12'h888, 8'h99, 8'h4D, 1'b0);
        waitFrames(0, base_frames + 1);
        tick();
        checkOutput("t6_in_gap", cs_n[0], 1'b1);
        spur_req[0]++;
        tick();
        tick();
        checkOutput("t6_rx_word_kept", rx_word[0], 16'h5566);
        waitFrames(0, base_frames + 2);
        checkOutput("t6_gap_cycles", last_gap[0], 4);
        waitIdle(0);
        checkOutput("t6_rx_word", rx_word[0], 16'h994D);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
